// File: rtl/nibble_acc_pkg.sv
// Shared widths and FSM state encoding for the nibble accumulator.
package nibble_acc_pkg;

    localparam int NIB_W = 4;   // adder / operand width
    localparam int ACC_W = 8;   // accumulator width (two nibbles)
    localparam int CNT_W = 8;   // operand counter width (COUNT up to 255)

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        ADD_LO = 2'd1,
        ADD_HI = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/fourbit_adder.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
module fourbit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    assign carry[0] = cin;

    // One full adder per bit; carry ripples from bit 0 upward.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[4];

endmodule

// File: rtl/nibble_accumulator.sv
// Frame accumulator: sums COUNT unsigned nibbles into an 8-bit result using a
// single 4-bit adder, applied first to the low nibble and then to the high
// nibble with the intermediate carry held in a register.
// COUNT must lie in 1..255 so that COUNT-1 fits the 8-bit counter.
module nibble_accumulator
    import nibble_acc_pkg::*;
#(
    parameter int COUNT = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_sum,
    output logic       out_ovf,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic               carry_reg;
    logic               ovf_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [NIB_W-1:0]   operand_reg;

    logic [NIB_W-1:0]   add_a;
    logic [NIB_W-1:0]   add_b;
    logic               add_cin;
    logic [NIB_W-1:0]   add_sum;
    logic               add_cout;

    // Adder operand mux: high-nibble pass adds only the saved carry,
    // every other state presents the low-nibble pass.
    always_comb begin
        add_a   = acc_reg[NIB_W-1:0];
        add_b   = operand_reg;
        add_cin = 1'b0;
        if (state_reg == ADD_HI) begin
            add_a   = acc_reg[ACC_W-1:NIB_W];
            add_b   = '0;
            add_cin = carry_reg;
        end
    end

    fourbit_adder u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // FSM and datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ACCEPT;
            acc_reg     <= '0;
            carry_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
            count_reg   <= '0;
            operand_reg <= '0;
        end else begin
            case (state_reg)
                ACCEPT: begin
                    if (in_valid) begin
                        operand_reg <= in_data;
                        state_reg   <= ADD_LO;
                    end
                end
                ADD_LO: begin
                    acc_reg[NIB_W-1:0] <= add_sum;
                    carry_reg          <= add_cout;
                    state_reg          <= ADD_HI;
                end
                ADD_HI: begin
                    acc_reg[ACC_W-1:NIB_W] <= add_sum;
                    // Overflow stays set for the rest of the frame.
                    if (add_cout) begin
                        ovf_reg <= 1'b1;
                    end
                    if (count_reg == LAST_IDX) begin
                        count_reg <= '0;
                        state_reg <= DONE;
                    end else begin
                        count_reg <= count_reg + 1'b1;
                        state_reg <= ACCEPT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        carry_reg <= 1'b0;
                        state_reg <= ACCEPT;
                    end
                end
                default: state_reg <= ACCEPT;
            endcase
        end
    end

    // Handshake and result outputs; result is gated to zero when not valid.
    always_comb begin
        in_ready  = (state_reg == ACCEPT);
        out_valid = (state_reg == DONE);
        out_sum   = out_valid ? acc_reg : '0;
        out_ovf   = out_valid & ovf_reg;
        busy      = !((state_reg == ACCEPT) && (count_reg == '0));
    end

endmodule

// File: tb/tb_nibble_accumulator.sv
// Directed bench for nibble_accumulator with a result scoreboard.
// Three instances (COUNT = 4, 20, 1) share the input stimulus; a selector
// picks which one is observed. Every test begins with a reset.
module tb_nibble_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       out_ready = 1'b1;

    logic       in_ready_d  [3];
    logic       out_valid_d [3];
    logic [7:0] out_sum_d   [3];
    logic       out_ovf_d   [3];
    logic       busy_d      [3];

    logic       obs_in_ready, obs_out_valid, obs_out_ovf, obs_busy;
    logic [7:0] obs_out_sum;
    int         sel = 0;

    int tests = 0;
    int fails = 0;
    logic [8:0] sb[$];      // {sum, ovf}
    logic [8:0] mon_e;

    always #5 clk = ~clk;

    nibble_accumulator #(.COUNT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[0]),
        .in_data(in_data), .out_valid(out_valid_d[0]), .out_ready(out_ready),
        .out_sum(out_sum_d[0]), .out_ovf(out_ovf_d[0]), .busy(busy_d[0]));

    nibble_accumulator #(.COUNT(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[1]),
        .in_data(in_data), .out_valid(out_valid_d[1]), .out_ready(out_ready),
        .out_sum(out_sum_d[1]), .out_ovf(out_ovf_d[1]), .busy(busy_d[1]));

    nibble_accumulator #(.COUNT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d[2]),
        .in_data(in_data), .out_valid(out_valid_d[2]), .out_ready(out_ready),
        .out_sum(out_sum_d[2]), .out_ovf(out_ovf_d[2]), .busy(busy_d[2]));

    always_comb begin
        obs_in_ready  = in_ready_d[sel];
        obs_out_valid = out_valid_d[sel];
        obs_out_sum   = out_sum_d[sel];
        obs_out_ovf   = out_ovf_d[sel];
        obs_busy      = busy_d[sel];
    end

    task automatic check(input string tag, input logic [8:0] act, input logic [8:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: frame total -> {total mod 256, total > 255}.
    task automatic push_expect(input int total);
        logic [7:0] s;
        s = 8'(total % 256);
        sb.push_back({s, (total > 255) ? 1'b1 : 1'b0});
    endtask

    // Scoreboard consumer: a handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && obs_out_valid && out_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_result: got sum %0h, no result expected", obs_out_sum);
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                $display("[TB] result sum=%02h ovf=%0d (expected %02h/%0d)",
                         obs_out_sum, obs_out_ovf, mon_e[8:1], mon_e[0]);
                check("out_sum", {1'b0, obs_out_sum}, {1'b0, mon_e[8:1]});
                check("out_ovf", {8'h0, obs_out_ovf}, {8'h0, mon_e[0]});
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    // waits = number of sampled cycles in_ready was low before acceptance.
    task automatic send(input logic [3:0] op, output int waits);
        in_valid = 1'b1;
        in_data  = op;
        waits    = 0;
        @(negedge clk);
        while (!obs_in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!obs_in_ready) begin
            check("send_timeout", 9'd0, 9'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("[TB] sent operand %h after %0d wait cycles", op, waits);
    endtask

    task automatic send_n(input int n, input logic [3:0] op);
        int w;
        for (int i = 0; i < n; i++) send(op, w);
    endtask

    // Wait (bounded) until the scoreboard has consumed all expected results.
    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 9'(sb.size()), 9'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        sel       = s;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        int total;
        int n;

        // Reset state
        do_reset(0);
        @(negedge clk);
        check("rst_in_ready",  {8'h0, obs_in_ready},  9'd1);
        check("rst_out_valid", {8'h0, obs_out_valid}, 9'd0);
        check("rst_out_sum",   {1'b0, obs_out_sum},   9'd0);
        check("rst_out_ovf",   {8'h0, obs_out_ovf},   9'd0);
        check("rst_busy",      {8'h0, obs_busy},      9'd0);
        @(posedge clk);
        #1;

        // 1,2,3,4 back-to-back: in_ready low for 2 cycles after each accept
        send(4'h1, w);
        check("b2b_busy", {8'h0, busy_d[0]}, 9'd1);
        for (int i = 2; i <= 4; i++) begin
            if (i == 4) push_expect(1 + 2 + 3 + 4);
            send(4'(i), w);
            check("b2b_wait", 9'(w), 9'd2);
        end
        drain("b2b");
        @(negedge clk);
        check("b2b_in_ready_back", {8'h0, obs_in_ready}, 9'd1);
        check("b2b_busy_idle",     {8'h0, obs_busy},     9'd0);

        // F,F,F,F: carry into the high nibble
        do_reset(0);
        push_expect(4 * 15);
        send_n(4, 4'hF);
        drain("ffff");

        // COUNT=20: overflow frame, then zero frame clears ovf
        do_reset(1);
        push_expect(20 * 15);
        send_n(20, 4'hF);
        drain("ovf20");
        push_expect(0);
        send_n(20, 4'h0);
        drain("zero20");

        // Backpressure: out_ready low while DONE is held
        do_reset(0);
        out_ready = 1'b0;
        push_expect(4 * 5);
        send_n(4, 4'h5);
        n = 0;
        @(negedge clk);
        while (!obs_out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_reached_done", {8'h0, obs_out_valid}, 9'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", {8'h0, obs_out_valid}, 9'd1);
            check("bp_out_sum",   {1'b0, obs_out_sum},   9'h14);
            check("bp_in_ready",  {8'h0, obs_in_ready},  9'd0);
            check("bp_busy",      {8'h0, obs_busy},      9'd1);
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0);
            in_data  = 4'hF;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_out_valid_drop", {8'h0, obs_out_valid}, 9'd0);
        check("bp_in_ready_back",  {8'h0, obs_in_ready},  9'd1);
        check("bp_sb_empty",       9'(sb.size()),         9'd0);
        @(posedge clk);
        #1;

        // Random idle gaps between operands 7,8,9,A
        do_reset(0);
        push_expect(7 + 8 + 9 + 10);
        for (int i = 0; i < 4; i++) begin
            repeat ($urandom_range(5, 1)) @(posedge clk);
            #1;
            send(4'(7 + i), w);
        end
        drain("gaps");

        // Asynchronous reset during ADD_HI of the 3rd operand
        do_reset(0);
        send_n(3, 4'h9);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {8'h0, obs_in_ready},  9'd1);
        check("arst_out_valid", {8'h0, obs_out_valid}, 9'd0);
        check("arst_busy",      {8'h0, obs_busy},      9'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_expect(4);
        send_n(4, 4'h1);
        drain("after_arst");

        // COUNT=1: each operand is its own frame
        do_reset(2);
        total = 0;
        push_expect(7);
        send(4'h7, w);
        drain("c1_a");
        push_expect(15);
        send(4'hF, w);
        drain("c1_b");

        check("final_sb_empty", 9'(sb.size()), 9'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
